// File: rtl/wordle_pkg.sv
// Shared constants and state encoding for guess entry; no logic, no latency.
// The one-hot state values double as the q_Idle/q_Edit/q_Send flag bits.
package wordle_pkg;
  localparam int WORD_LEN = 5;
  localparam int LETTER_W = 8;
  localparam int CUR_W    = 3;
  localparam int WORD_W   = WORD_LEN * LETTER_W;

  localparam logic [LETTER_W-1:0] ASCII_A = 8'h41;
  localparam logic [LETTER_W-1:0] ASCII_Z = 8'h5A;
  localparam logic [LETTER_W-1:0] BLANK   = 8'h00;
  localparam logic [CUR_W-1:0]    LAST_IDX = CUR_W'(WORD_LEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'b100,
    EDIT = 3'b010,
    SEND = 3'b001
  } state_e;
endpackage

// File: rtl/wordle_guess_entry_if.sv
// Buttons/enable in, guess valid/ack handshake and display view out.
// master = guess-entry producer; slave = game FSM / display side.
interface wordle_guess_entry_if;
  import wordle_pkg::*;

  logic                enable;
  logic                BtnU;
  logic                BtnD;
  logic                BtnR;
  logic                BtnL;
  logic                BtnC;
  logic                guess_ack;
  logic                guess_valid;
  logic [WORD_W-1:0]   guess_word;
  logic [WORD_W-1:0]   entry_word;
  logic [LETTER_W-1:0] cur_char;
  logic [CUR_W-1:0]    cursor;
  logic                q_Idle;
  logic                q_Edit;
  logic                q_Send;

  modport master (
    input  enable, BtnU, BtnD, BtnR, BtnL, BtnC, guess_ack,
    output guess_valid, guess_word, entry_word, cur_char, cursor,
           q_Idle, q_Edit, q_Send
  );

  modport slave (
    output enable, BtnU, BtnD, BtnR, BtnL, BtnC, guess_ack,
    input  guess_valid, guess_word, entry_word, cur_char, cursor,
           q_Idle, q_Edit, q_Send
  );
endinterface

// File: rtl/wordle_letter_cycler.sv
// A..Z up/down wrapping letter register; result visible one cycle after the request.
// Priority clr > load > up > dn; no backpressure.
module wordle_letter_cycler
  import wordle_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [LETTER_W-1:0] load_dat_i,
  input  logic                up_i,
  input  logic                dn_i,
  output logic [LETTER_W-1:0] letter_o
);
  logic [LETTER_W-1:0] letter_q, letter_d;

  always_comb begin
    letter_d = letter_q;
    if (clr_i)       letter_d = ASCII_A;
    else if (load_i) letter_d = load_dat_i;
    else if (up_i)   letter_d = (letter_q == ASCII_Z) ? ASCII_A : letter_q + 8'd1;
    else if (dn_i)   letter_d = (letter_q == ASCII_A) ? ASCII_Z : letter_q - 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) letter_q <= ASCII_A;
    else          letter_q <= letter_d;
  end

  assign letter_o = letter_q;
endmodule

// File: rtl/wordle_guess_entry.sv
// Button-driven 5-letter guess editor; edits land next cycle, guess_valid rises the cycle after the 5th commit.
// guess_valid/guess_word are held until guess_ack; buttons are ignored while waiting.
module wordle_guess_entry
  import wordle_pkg::*;
(
  input  logic                 Clk,
  input  logic                 reset,
  wordle_guess_entry_if.master bus
);
  state_e              state_q, state_d;
  logic [LETTER_W-1:0] slot_q [WORD_LEN];
  logic [LETTER_W-1:0] slot_d [WORD_LEN];
  logic [CUR_W-1:0]    cursor_q, cursor_d;
  logic                valid_q, valid_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   entry_w;
  logic [LETTER_W-1:0] cur_char;
  logic [CUR_W-1:0]    cur_m1;
  logic                clear_buf;
  logic                cyc_clr, cyc_load, cyc_up, cyc_dn;
  logic [LETTER_W-1:0] cyc_ld_dat;

  wordle_letter_cycler u_cycler (
    .clk_i      (Clk),
    .rst_n_i    (reset),
    .clr_i      (cyc_clr),
    .load_i     (cyc_load),
    .load_dat_i (cyc_ld_dat),
    .up_i       (cyc_up),
    .dn_i       (cyc_dn),
    .letter_o   (cur_char)
  );

  // slot0 sits in the most significant byte
  always_comb begin
    entry_w = '0;
    for (int i = 0; i < WORD_LEN; i++)
      entry_w[(WORD_LEN-1-i)*LETTER_W +: LETTER_W] = slot_q[i];
  end

  assign cur_m1 = cursor_q - CUR_W'(1);

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    cursor_d   = cursor_q;
    valid_d    = valid_q;
    word_d     = word_q;
    clear_buf  = 1'b0;
    cyc_clr    = 1'b0;
    cyc_load   = 1'b0;
    cyc_ld_dat = ASCII_A;
    cyc_up     = 1'b0;
    cyc_dn     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d   = EDIT;
          clear_buf = 1'b1;
        end
      end
      EDIT: begin
        if (!bus.enable) begin
          state_d   = IDLE;
          clear_buf = 1'b1;
        end else if (bus.BtnC) begin
          clear_buf = 1'b1;
        end else if (bus.BtnL) begin
          if (cursor_q != '0) begin
            cursor_d = cur_m1;
            cyc_load = 1'b1;
            for (int i = 0; i < WORD_LEN; i++) begin
              if (CUR_W'(i) == cur_m1) begin
                slot_d[i]  = BLANK;
                cyc_ld_dat = slot_q[i];
              end
            end
          end
        end else if (bus.BtnR) begin
          for (int i = 0; i < WORD_LEN; i++)
            if (CUR_W'(i) == cursor_q) slot_d[i] = cur_char;
          if (cursor_q < LAST_IDX) begin
            cursor_d = cursor_q + CUR_W'(1);
            cyc_clr  = 1'b1;
          end else begin
            // last letter comes straight from cur_char, not from the slot being written
            word_d  = {entry_w[WORD_W-1:LETTER_W], cur_char};
            valid_d = 1'b1;
            state_d = SEND;
          end
        end else if (bus.BtnU) begin
          cyc_up = 1'b1;
        end else if (bus.BtnD) begin
          cyc_dn = 1'b1;
        end
      end
      SEND: begin
        if (bus.guess_ack) begin
          valid_d   = 1'b0;
          clear_buf = 1'b1;
          state_d   = bus.enable ? EDIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_buf) begin
      for (int i = 0; i < WORD_LEN; i++) slot_d[i] = BLANK;
      cursor_d = '0;
      cyc_clr  = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cursor_q <= '0;
      valid_q  <= 1'b0;
      word_q   <= '0;
      for (int i = 0; i < WORD_LEN; i++) slot_q[i] <= BLANK;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      valid_q  <= valid_d;
      word_q   <= word_d;
      for (int i = 0; i < WORD_LEN; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign bus.guess_valid = valid_q;
  assign bus.guess_word  = word_q;
  assign bus.entry_word  = entry_w;
  assign bus.cur_char    = cur_char;
  assign bus.cursor      = cursor_q;
  assign bus.q_Idle      = (state_q == IDLE);
  assign bus.q_Edit      = (state_q == EDIT);
  assign bus.q_Send      = (state_q == SEND);
endmodule

// File: tb/tb_wordle_guess_entry.sv
// Directed bench for wordle_guess_entry: buttons change on the falling edge, outputs are sampled there too.
module tb_wordle_guess_entry;
  import wordle_pkg::*;

  logic Clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  localparam logic [4:0] BC = 5'b10000;
  localparam logic [4:0] BL = 5'b01000;
  localparam logic [4:0] BR = 5'b00100;
  localparam logic [4:0] BU = 5'b00010;
  localparam logic [4:0] BD = 5'b00001;

  wordle_guess_entry_if ifc ();

  wordle_guess_entry dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // drive {C,L,R,U,D} for exactly one rising edge
  task automatic pulse(input logic [4:0] b);
    {ifc.BtnC, ifc.BtnL, ifc.BtnR, ifc.BtnU, ifc.BtnD} = b;
    @(negedge Clk);
    {ifc.BtnC, ifc.BtnL, ifc.BtnR, ifc.BtnU, ifc.BtnD} = 5'b0;
  endtask

  // assumes cur_char starts at 'A'
  task automatic enter_letter(input logic [7:0] c);
    for (int k = 0; k < int'(c - 8'h41); k++) pulse(BU);
    pulse(BR);
  endtask

  initial begin
    reset         = 1'b0;
    ifc.enable    = 1'b0;
    ifc.guess_ack = 1'b0;
    {ifc.BtnC, ifc.BtnL, ifc.BtnR, ifc.BtnU, ifc.BtnD} = 5'b0;

    #12;
    chk("rst_idle",   40'(ifc.q_Idle), 40'd1);
    chk("rst_cursor", 40'(ifc.cursor), 40'd0);
    chk("rst_char",   40'(ifc.cur_char), 40'h41);
    chk("rst_entry",  ifc.entry_word, 40'h0);
    chk("rst_valid",  40'(ifc.guess_valid), 40'd0);
    chk("rst_word",   ifc.guess_word, 40'h0);
    @(negedge Clk);
    reset = 1'b1;

    pulse(BR);
    chk("idle_btn_ignored", ifc.entry_word, 40'h0);
    chk("idle_stays", 40'(ifc.q_Idle), 40'd1);

    ifc.enable = 1'b1;
    @(negedge Clk);
    chk("enter_edit", 40'(ifc.q_Edit), 40'd1);

    pulse(BD);
    chk("wrap_down", 40'(ifc.cur_char), 40'h5A);
    pulse(BU);
    chk("wrap_up", 40'(ifc.cur_char), 40'h41);
    pulse(BU | BD);
    chk("u_over_d", 40'(ifc.cur_char), 40'h42);
    pulse(BD);
    chk("down_b_to_a", 40'(ifc.cur_char), 40'h41);

    enter_letter(8'h52);
    enter_letter(8'h4F);
    enter_letter(8'h42);
    enter_letter(8'h4F);
    chk("robo_entry",  ifc.entry_word, 40'h524F424F00);
    chk("robo_cursor", 40'(ifc.cursor), 40'd4);
    chk("robo_valid",  40'(ifc.guess_valid), 40'd0);
    for (int k = 0; k < 19; k++) pulse(BU);
    chk("t_char", 40'(ifc.cur_char), 40'h54);
    pulse(BR);
    chk("robot_valid", 40'(ifc.guess_valid), 40'd1);
    chk("robot_word",  ifc.guess_word, 40'h524F424F54);
    chk("robot_send",  40'(ifc.q_Send), 40'd1);
    chk("robot_entry", ifc.entry_word, 40'h524F424F54);

    for (int k = 0; k < 10; k++) begin
      if (k == 3)      pulse(BC);
      else if (k == 6) pulse(BU);
      else             @(negedge Clk);
      chk("hold_valid", 40'(ifc.guess_valid), 40'd1);
    end
    chk("hold_word",  ifc.guess_word, 40'h524F424F54);
    chk("hold_entry", ifc.entry_word, 40'h524F424F54);
    chk("hold_char",  40'(ifc.cur_char), 40'h54);

    ifc.guess_ack = 1'b1;
    @(negedge Clk);
    ifc.guess_ack = 1'b0;
    chk("ack_valid",  40'(ifc.guess_valid), 40'd0);
    chk("ack_cursor", 40'(ifc.cursor), 40'd0);
    chk("ack_edit",   40'(ifc.q_Edit), 40'd1);
    chk("ack_entry",  ifc.entry_word, 40'h0);
    chk("ack_char",   40'(ifc.cur_char), 40'h41);
    chk("ack_word_kept", ifc.guess_word, 40'h524F424F54);

    enter_letter(8'h41);
    enter_letter(8'h42);
    chk("ab_entry",  ifc.entry_word, 40'h4142000000);
    chk("ab_cursor", 40'(ifc.cursor), 40'd2);
    pulse(BL);
    chk("bs1_cursor", 40'(ifc.cursor), 40'd1);
    chk("bs1_entry",  ifc.entry_word, 40'h4100000000);
    chk("bs1_char",   40'(ifc.cur_char), 40'h42);
    pulse(BL);
    chk("bs2_cursor", 40'(ifc.cursor), 40'd0);
    chk("bs2_entry",  ifc.entry_word, 40'h0);
    chk("bs2_char",   40'(ifc.cur_char), 40'h41);
    pulse(BU);
    pulse(BL);
    chk("bs3_cursor", 40'(ifc.cursor), 40'd0);
    chk("bs3_char",   40'(ifc.cur_char), 40'h42);

    pulse(BU);
    pulse(BR | BU);
    chk("ru_entry",  ifc.entry_word, 40'h4300000000);
    chk("ru_cursor", 40'(ifc.cursor), 40'd1);
    chk("ru_char",   40'(ifc.cur_char), 40'h41);
    pulse(BU);
    pulse(BC | BR);
    chk("cr_entry",  ifc.entry_word, 40'h0);
    chk("cr_cursor", 40'(ifc.cursor), 40'd0);
    chk("cr_char",   40'(ifc.cur_char), 40'h41);

    enter_letter(8'h44);
    ifc.enable = 1'b0;
    pulse(BR);
    chk("dis_idle",   40'(ifc.q_Idle), 40'd1);
    chk("dis_entry",  ifc.entry_word, 40'h0);
    chk("dis_cursor", 40'(ifc.cursor), 40'd0);
    ifc.guess_ack = 1'b1;
    pulse(BR);
    ifc.guess_ack = 1'b0;
    chk("idle_ack_ignored", 40'(ifc.q_Idle), 40'd1);

    ifc.enable = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 4; k++) enter_letter(8'h41);
    enter_letter(8'h45);
    chk("s2_valid", 40'(ifc.guess_valid), 40'd1);
    chk("s2_word",  ifc.guess_word, 40'h4141414145);
    ifc.enable = 1'b0;
    repeat (3) @(negedge Clk);
    chk("s2_hold_valid", 40'(ifc.guess_valid), 40'd1);
    chk("s2_hold_send",  40'(ifc.q_Send), 40'd1);
    ifc.guess_ack = 1'b1;
    @(negedge Clk);
    ifc.guess_ack = 1'b0;
    chk("s2_ack_valid", 40'(ifc.guess_valid), 40'd0);
    chk("s2_ack_idle",  40'(ifc.q_Idle), 40'd1);
    chk("s2_ack_entry", ifc.entry_word, 40'h0);

    ifc.enable = 1'b1;
    @(negedge Clk);
    enter_letter(8'h41);
    enter_letter(8'h42);
    enter_letter(8'h43);
    pulse(BU);
    chk("pre_rst_cursor", 40'(ifc.cursor), 40'd3);
    #2 reset = 1'b0;
    #1;
    chk("arst_idle",   40'(ifc.q_Idle), 40'd1);
    chk("arst_cursor", 40'(ifc.cursor), 40'd0);
    chk("arst_char",   40'(ifc.cur_char), 40'h41);
    chk("arst_entry",  ifc.entry_word, 40'h0);
    chk("arst_valid",  40'(ifc.guess_valid), 40'd0);
    @(negedge Clk);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
